// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows (stride 2) for max_pool.
// Even rows are parked in a one-line buffer and paired with the odd row as it streams past.
module pool_window_gen #(
   parameter int DATA_W = 13,
   parameter int IMG_W  = 26,
   parameter int IMG_H  = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic [DATA_W-1:0] win_p0,
   output logic [DATA_W-1:0] win_p1,
   output logic [DATA_W-1:0] win_p2,
   output logic [DATA_W-1:0] win_p3,
   output logic              win_valid,
   output logic              frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col_m1;
   logic [DATA_W-1:0] prev_pix;
   logic [DATA_W-1:0] row_buf [IMG_W];
   logic              col_end;
   logic              row_end;
   logic              win_done;

   assign col_end  = (col == COL_LAST);
   assign row_end  = (row == ROW_LAST);
   assign col_m1   = col - CW'(1);
   // With odd dimensions the trailing column/row has an even index, so it never completes a window.
   assign win_done = pix_valid && row[0] && col[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffer is never cleared; odd rows only read entries the preceding even row rewrote.
   always_ff @(posedge clk) begin
      if (!rst && pix_valid && !row[0]) begin
         row_buf[col] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_pix <= '0;
      end else if (pix_valid && row[0] && !col[0]) begin
         prev_pix <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_p0     <= '0;
         win_p1     <= '0;
         win_p2     <= '0;
         win_p3     <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= win_done;
         frame_done <= pix_valid && col_end && row_end;
         if (win_done) begin
            win_p0 <= row_buf[col_m1];
            win_p1 <= row_buf[col];
            win_p2 <= prev_pix;
            win_p3 <= pix_in;
         end
      end
   end

endmodule
